// File: rtl/mod_pkg.sv
// Shared types and constants for the modulo-request arbiter.
package mod_pkg;

  localparam int unsigned DEFAULT_WIDTH = 32;
  localparam int unsigned NREQ_MIN      = 2;
  localparam int unsigned NREQ_MAX      = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_WAIT   = 2'd2,
    ST_RESP   = 2'd3
  } arb_state_e;

endpackage

// File: rtl/rr_select.sv
// Round-robin selector: first requester after index 'last', wrapping around.
module rr_select
  import mod_pkg::*;
#(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   last,
  output logic [NREQ-1:0] grant,
  output logic [IW-1:0]   idx
);

  // Scan last+1 .. last+NREQ so the previous winner is checked last.
  always_comb begin
    logic        found;
    int unsigned k;
    grant = '0;
    idx   = '0;
    found = 1'b0;
    k     = 0;
    for (int unsigned i = 1; i <= NREQ; i++) begin
      k = (32'(last) + i) % NREQ;
      if (!found && req[IW'(k)]) begin
        found          = 1'b1;
        grant[IW'(k)]  = 1'b1;
        idx            = IW'(k);
      end
    end
  end

endmodule

// File: rtl/mod_arbiter.sv
// Round-robin arbiter that serves one A mod B request at a time through an
// external modulo unit, with divide-by-zero and timeout handling.
module mod_arbiter
  import mod_pkg::*;
#(
  parameter int unsigned WIDTH   = DEFAULT_WIDTH,
  parameter int unsigned NREQ    = 4,
  parameter int unsigned TIMEOUT = WIDTH + 8
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [NREQ-1:0]            req,
  input  logic [NREQ-1:0][WIDTH-1:0] a_in,
  input  logic [NREQ-1:0][WIDTH-1:0] b_in,
  output logic [NREQ-1:0]            gnt,
  output logic [NREQ-1:0]            done,
  output logic [WIDTH-1:0]           result,
  output logic                       err,
  output logic                       busy,
  output logic                       mod_ena,
  output logic [WIDTH-1:0]           mod_a,
  output logic [WIDTH-1:0]           mod_b,
  output logic                       mod_rst,
  input  logic [WIDTH-1:0]           mod_result,
  input  logic                       mod_write
);

  localparam int unsigned IW = $clog2(NREQ);
  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  if (NREQ < NREQ_MIN || NREQ > NREQ_MAX) begin : g_bad_nreq
    $error("mod_arbiter: NREQ outside supported range");
  end

  arb_state_e       r_state;
  logic [IW-1:0]    r_last;
  logic [IW-1:0]    r_idx;
  logic [NREQ-1:0]  r_gnt;
  logic [NREQ-1:0]  r_done;
  logic [WIDTH-1:0] r_result;
  logic             r_err;
  logic             r_busy;
  logic             r_mod_ena;
  logic             r_mod_rst;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [TW-1:0]    r_timer;

  logic [NREQ-1:0]  w_grant;
  logic [IW-1:0]    w_idx;

  rr_select #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_rr_select (
    .req   (req),
    .last  (r_last),
    .grant (w_grant),
    .idx   (w_idx)
  );

  // Request FSM; done, mod_ena and mod_rst are single-cycle pulses.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state   <= ST_IDLE;
      r_last    <= IW'(NREQ - 1);
      r_idx     <= '0;
      r_gnt     <= '0;
      r_done    <= '0;
      r_result  <= '0;
      r_err     <= 1'b0;
      r_busy    <= 1'b0;
      r_mod_ena <= 1'b0;
      r_mod_rst <= 1'b0;
      r_a       <= '0;
      r_b       <= '0;
      r_timer   <= '0;
    end else begin
      r_done    <= '0;
      r_mod_ena <= 1'b0;
      r_mod_rst <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (|req) begin
            r_idx  <= w_idx;
            r_gnt  <= w_grant;
            r_a    <= a_in[w_idx];
            r_b    <= b_in[w_idx];
            r_busy <= 1'b1;
            if (b_in[w_idx] == '0) begin
              // Zero modulus never reaches the modulo unit.
              r_result <= '0;
              r_err    <= 1'b1;
              r_done   <= w_grant;
              r_state  <= ST_RESP;
            end else begin
              r_mod_ena <= 1'b1;
              r_state   <= ST_LAUNCH;
            end
          end
        end
        ST_LAUNCH: begin
          r_timer <= '0;
          r_state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (mod_write) begin
            r_result <= mod_result;
            r_err    <= 1'b0;
            r_done   <= r_gnt;
            r_state  <= ST_RESP;
          end else if (r_timer == TW'(TIMEOUT - 1)) begin
            r_mod_rst <= 1'b1;
            r_result  <= '0;
            r_err     <= 1'b1;
            r_done    <= r_gnt;
            r_state   <= ST_RESP;
          end else begin
            r_timer <= r_timer + TW'(1);
          end
        end
        ST_RESP: begin
          r_last  <= r_idx;
          r_gnt   <= '0;
          r_busy  <= 1'b0;
          r_a     <= '0;
          r_b     <= '0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign gnt     = r_gnt;
  assign done    = r_done;
  assign result  = r_result;
  assign err     = r_err;
  assign busy    = r_busy;
  assign mod_ena = r_mod_ena;
  assign mod_a   = r_a;
  assign mod_b   = r_b;
  // Reset also clears the modulo unit on its next clock edge.
  assign mod_rst = ~reset | r_mod_rst;

endmodule

// File: doc/mod_arbiter.md
MOD_ARBITER -- requirements
Module: mod_arbiter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, operand/result width.
REQ-002 The block SHALL have parameter NREQ, default 4, number of requesters (2..8).
REQ-003 The block SHALL have parameter TIMEOUT, default WIDTH+8, maximum number of WAIT cycles before abort.
REQ-004 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-005 clock  input  1  rising-edge clock.
REQ-006 reset  input  1  asynchronous, active-low reset.
REQ-007 req  input  NREQ  per-requester request level.
REQ-008 a_in  input  NREQ x WIDTH  per-requester dividend.
REQ-009 b_in  input  NREQ x WIDTH  per-requester modulus.
REQ-010 gnt  output  NREQ  one-hot grant; all zero when no requester is being served.
REQ-011 done  output  NREQ  one-cycle completion pulse to the winning requester.
REQ-012 result  output  WIDTH  A mod B; valid while any done bit is high.
REQ-013 err  output  1  error flag (B==0 or timeout); valid while any done bit is high.
REQ-014 busy  output  1  high in every state except IDLE.
REQ-015 mod_ena  output  1  single-cycle start pulse to the modulo unit.
REQ-016 mod_a, mod_b  output  WIDTH  operands to the modulo unit.
REQ-017 mod_rst  output  1  active-high synchronous reset to the modulo unit.
REQ-018 mod_result  input  WIDTH  remainder from the modulo unit.
REQ-019 mod_write  input  1  modulo-unit completion strobe.

Function
REQ-020 The FSM SHALL have four states: IDLE, LAUNCH, WAIT, RESP.
REQ-021 In IDLE with any req bit high, the block SHALL select a winner round-robin, starting at index last+1 mod NREQ.
REQ-022 On that selection the block SHALL latch the winner's operands into internal registers.
REQ-023 From IDLE the block SHALL go to LAUNCH, or directly to RESP if the latched b equals 0.
REQ-024 gnt SHALL be one-hot on the winner from the cycle after selection through RESP inclusive.
REQ-025 In LAUNCH the block SHALL hold mod_ena=1 for exactly one cycle, then go to WAIT.
REQ-026 mod_a and mod_b SHALL be driven from the latched registers, stable from LAUNCH through the end of WAIT.
REQ-027 mod_a and mod_b SHALL be 0 in IDLE.
REQ-028 In WAIT the timer SHALL be cleared on entry and increment each cycle.
REQ-029 If mod_write=1 in WAIT, the block SHALL capture mod_result into result, set err=0 and go to RESP.
REQ-030 If the timer reaches TIMEOUT without mod_write, the block SHALL pulse mod_rst for one cycle, set result=0 and err=1, and go to RESP.
REQ-031 If mod_write and the timeout occur in the same cycle, mod_write SHALL win and no mod_rst pulse is issued.
REQ-032 For B==0 the block SHALL return result=0 and err=1 without asserting mod_ena.
REQ-033 In RESP the block SHALL pulse done[winner] for one cycle, update last to the winner and return to IDLE.
REQ-034 A requester SHALL hold req and its operands until done; deasserting req after selection does not abort the operation.
REQ-035 mod_write outside WAIT SHALL be ignored.
REQ-036 A requester still asserting req in the IDLE cycle after RESP SHALL be re-arbitrated with lowest priority.

Reset
REQ-037 While reset=0, the block SHALL force state=IDLE, last=NREQ-1, and gnt, done, result, err, busy, mod_ena, mod_a and mod_b all to 0.
REQ-038 While reset=0, mod_rst SHALL be 1 (combinational from reset) so the modulo unit clears at the next clock edge.
REQ-039 Reset asserted mid-operation SHALL discard the operation silently, with no done pulse.

Structure
REQ-040 A shared package mod_pkg SHALL hold the state enum type, the default WIDTH, and the NREQ-bounds constants.
REQ-041 The round-robin selector SHALL be a separate sub-module rr_select (inputs req and last; outputs one-hot grant and index).
REQ-042 The modulo unit SHALL be instantiated outside this block, at the level above it.

Verification
REQ-043 With the real modulo unit connected, req[1] with a=17, b=5 SHALL produce done[1] with result=2, err=0, and exactly one mod_ena pulse.
REQ-044 Operands a=9, b=9 SHALL produce result=0; operands a=3, b=7 SHALL produce result=3, each with err=0.
REQ-045 With req[0] and req[2] raised together from reset, service order SHALL be 0 then 2; a following req[3] together with req[0] SHALL serve 3 before 0.
REQ-046 b=0 SHALL produce done with err=1 and result=0, no mod_ena, and a total latency of 2 cycles from selection.
REQ-047 With mod_write stubbed low, the block SHALL pulse mod_rst at WAIT cycle TIMEOUT and then produce done with err=1.
REQ-048 Reset asserted during WAIT SHALL return all outputs to 0 immediately with mod_rst=1; after release a new req SHALL complete correctly.
